// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - one-hot seven-segment digit scan with dwell, direction and skip mask
module digit_scan_ctrl #(
    parameter int DIGITS     = 8,
    parameter int DWELL_W    = 16,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int IDX_W     = $clog2(DIGITS)
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DIGITS-1:0]  digit_mask,
    output logic [DIGITS-1:0]  select,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               frame_start
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{ACTIVE_LOW}};

    logic [0:0]         r_state;
    logic [DIGITS-1:0]  r_select;
    logic [IDX_W-1:0]   r_idx;
    logic               r_frame_start;
    logic [DWELL_W-1:0] r_cnt;

    logic [IDX_W-1:0]   w_first_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_mask_any;
    logic               w_advance;

    function automatic logic [DIGITS-1:0] sel_of(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return ACTIVE_LOW ? ~v : v;
    endfunction

    assign w_mask_any = |digit_mask;

    // Frame origin: highest set bit when descending, lowest when ascending.
    always_comb begin
        w_first_idx = '0;
        if (dir) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                if (digit_mask[i]) w_first_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (digit_mask[i]) w_first_idx = IDX_W'(i);
            end
        end
    end

    // Nearest set bit strictly beyond r_idx; scanning far-to-near leaves the nearest hit.
    // k = DIGITS lands back on r_idx, which covers the single-digit mask.
    always_comb begin
        int cand;
        cand       = 0;
        w_next_idx = r_idx;
        for (int k = DIGITS; k >= 1; k--) begin
            if (dir) cand = (int'(r_idx) + k) % DIGITS;
            else     cand = (int'(r_idx) + DIGITS - k) % DIGITS;
            if (digit_mask[cand]) w_next_idx = IDX_W'(cand);
        end
    end

    assign w_advance = (r_cnt == '0) || !digit_mask[r_idx];

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_select      <= SEL_OFF;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
            r_cnt         <= '0;
        end else if (!en) begin
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_start <= 1'b0;
                    if (w_mask_any) begin
                        r_state       <= ST_SCAN;
                        r_idx         <= w_first_idx;
                        r_select      <= sel_of(w_first_idx);
                        r_cnt         <= dwell;
                        r_frame_start <= 1'b1;
                    end
                end
                default: begin
                    if (!w_mask_any) begin
                        r_state       <= ST_IDLE;
                        r_select      <= SEL_OFF;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_frame_start <= 1'b0;
                    end else if (w_advance) begin
                        r_idx         <= w_next_idx;
                        r_select      <= sel_of(w_next_idx);
                        r_cnt         <= dwell;
                        r_frame_start <= (w_next_idx == w_first_idx);
                    end else begin
                        r_cnt         <= r_cnt - DWELL_W'(1);
                        r_frame_start <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign select      = r_select;
    assign digit_idx   = r_idx;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - directed bench for digit_scan_ctrl (8-digit high and 4-digit active-low)
module tb_digit_scan_ctrl;

    logic        clk_div = 1'b0;
    logic        rst     = 1'b1;

    logic        en = 1'b0, dir = 1'b0;
    logic [15:0] dwell = '0;
    logic [7:0]  mask  = '0;
    logic [7:0]  sel;
    logic [2:0]  idx;
    logic        fs;

    logic        en2 = 1'b0, dir2 = 1'b0;
    logic [15:0] dwell2 = '0;
    logic [3:0]  mask2  = '0;
    logic [3:0]  sel2;
    logic [1:0]  idx2;
    logic        fs2;

    int checks = 0;
    int errors = 0;

    always #5 clk_div = ~clk_div;

    digit_scan_ctrl #(.DIGITS(8), .DWELL_W(16), .ACTIVE_LOW(1'b0)) u_dut (
        .clk_div(clk_div), .rst(rst), .en(en), .dir(dir), .dwell(dwell),
        .digit_mask(mask), .select(sel), .digit_idx(idx), .frame_start(fs)
    );

    digit_scan_ctrl #(.DIGITS(4), .DWELL_W(16), .ACTIVE_LOW(1'b1)) u_dut_low (
        .clk_div(clk_div), .rst(rst), .en(en2), .dir(dir2), .dwell(dwell2),
        .digit_mask(mask2), .select(sel2), .digit_idx(idx2), .frame_start(fs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] s, input logic [2:0] i, input logic f);
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".idx"}, 32'(idx), 32'(i));
        chk({tag, ".fs"},  32'(fs),  32'(f));
    endtask

    initial begin
        logic [7:0] seq8 [9];
        logic [3:0] seq4 [5];
        seq8 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        seq4 = '{4'h7, 4'hB, 4'hD, 4'hE, 4'h7};

        // reset state
        tick();
        chk8("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.sel_low", 32'(sel2), 32'hF);
        rst = 1'b0;

        // descending, dwell 0, full mask
        en = 1'b1; dwell = 16'd0; mask = 8'hFF; dir = 1'b0;
        for (int n = 0; n < 9; n++) begin
            tick();
            chk8($sformatf("desc%0d", n), seq8[n], 3'(7 - (n % 8)), (n == 0 || n == 8));
        end

        // ascending, dwell 2: each digit held 3 cycles, wrap 80 -> 01 pulses frame_start
        dwell = 16'd2; dir = 1'b1;
        for (int d = 0; d < 9; d++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk8($sformatf("asc%0d_%0d", d, c), 8'(1 << (d % 8)), 3'(d % 8), (c == 0 && d % 8 == 0));
            end
        end

        // mask skip A5, descending, dwell 0
        mask = 8'hA5; dir = 1'b0; dwell = 16'd0;
        tick(); chk8("skip0", 8'h80, 3'd7, 1'b1);
        tick(); chk8("skip1", 8'h20, 3'd5, 1'b0);
        tick(); chk8("skip2", 8'h04, 3'd2, 1'b0);
        tick(); chk8("skip3", 8'h01, 3'd0, 1'b0);
        tick(); chk8("skip4", 8'h80, 3'd7, 1'b1);
        tick(); chk8("skip5", 8'h20, 3'd5, 1'b0);
        mask = 8'h85;
        tick(); chk8("clr5", 8'h04, 3'd2, 1'b0);
        mask = 8'h00;
        tick(); chk8("clrall", 8'h00, 3'd0, 1'b0);
        tick(); chk8("idle_hold", 8'h00, 3'd0, 1'b0);

        // clearing the current bit cuts a long dwell short; new digit is frame origin
        mask = 8'hFF; dwell = 16'd3;
        tick(); chk8("cut0", 8'h80, 3'd7, 1'b1);
        tick(); chk8("cut1", 8'h80, 3'd7, 1'b0);
        mask = 8'h7F;
        tick(); chk8("cut2", 8'h40, 3'd6, 1'b1);
        tick(); chk8("cut3", 8'h40, 3'd6, 1'b0);
        mask = 8'h00;
        tick(); chk8("cut_idle", 8'h00, 3'd0, 1'b0);

        // single digit, dwell 1: frame_start every second cycle
        mask = 8'h08; dwell = 16'd1;
        tick(); chk8("single0", 8'h08, 3'd3, 1'b1);
        tick(); chk8("single1", 8'h08, 3'd3, 1'b0);
        tick(); chk8("single2", 8'h08, 3'd3, 1'b1);
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(); chk8($sformatf("freeze%0d", n), 8'h08, 3'd3, 1'b0);
        end
        en = 1'b1;
        tick(); chk8("thaw0", 8'h08, 3'd3, 1'b0);
        tick(); chk8("thaw1", 8'h08, 3'd3, 1'b1);

        // asynchronous reset while 10 is selected
        mask = 8'h00;
        tick(); chk8("pre_rst_idle", 8'h00, 3'd0, 1'b0);
        mask = 8'hFF; dwell = 16'd0;
        tick(); tick(); tick(); tick();
        chk8("pre_rst", 8'h10, 3'd4, 1'b0);
        #2 rst = 1'b1;
        #1 chk8("async_rst", 8'h00, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick(); chk8("restart", 8'h80, 3'd7, 1'b1);
        tick(); chk8("restart1", 8'h40, 3'd6, 1'b0);

        // active-low 4-digit instance
        chk("low.idle", 32'(sel2), 32'hF);
        en2 = 1'b1; mask2 = 4'hF; dwell2 = 16'd0; dir2 = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("low%0d.sel", n), 32'(sel2), 32'(seq4[n]));
            chk($sformatf("low%0d.idx", n), 32'(idx2), 32'(3 - (n % 4)));
            chk($sformatf("low%0d.fs", n),  32'(fs2),  32'(n == 0 || n == 4));
        end
        mask2 = 4'h0;
        tick(); chk("low.back_idle", 32'(sel2), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Parametrised one-hot digit-select generator for multiplexed seven-segment display scanning. Runs on the divided display clock and drives the common-anode/cathode select lines. It adds several features over a fixed 8-bit ring:
- programmable digit count and per-digit dwell time
- scan direction control
- per-digit enable mask that skips blanked digits
- a frame-start strobe for the segment data path

Parameters:
DIGITS, 8, number of digit select lines (2..16)
DWELL_W, 16, width of dwell reload value
ACTIVE_LOW, 0, 1 inverts select output (0 = one-hot high)

Ports:
clk_div  input  1  divided scan clock, rising-edge
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; 0 freezes all state
dir  input  1  0 = descending index (MSB->LSB), 1 = ascending
dwell  input  DWELL_W  cycles per digit minus 1
digit_mask  input  DIGITS  1 = digit participates in scan
select  output  DIGITS  one-hot digit select (polarity per ACTIVE_LOW)
digit_idx  output  clog2(DIGITS)  index of currently selected digit
frame_start  output  1  one-cycle pulse when first digit of a frame is selected

Behaviour:
- Single clock. Reset is asynchronous and active-high. All outputs registered.
- Reset values:
  - state = IDLE
  - select = all inactive (0s, or 1s if ACTIVE_LOW)
  - digit_idx = 0
  - frame_start = 0
  - dwell counter = 0
- First digit of a frame: highest-index set bit of digit_mask when dir=0; lowest-index set bit when dir=1.
- Next digit: nearest set mask bit strictly beyond the current index in scan direction, wrapping modulo DIGITS. Masked digits are skipped within the same cycle, so there are no dead slots.
- IDLE -> SCAN: on the edge where en=1 and digit_mask != 0.
  - select = first digit, digit_idx set, counter loaded with dwell.
  - frame_start = 1 for that one cycle.
- SCAN, en=1, counter != 0: decrement counter; select unchanged.
- SCAN, en=1, counter == 0: advance to next digit and reload dwell.
  - frame_start = 1 in the cycle the new digit is the first digit, i.e. on wrap.
  - Each digit is therefore held exactly dwell+1 cycles.
  - dwell = 0 advances every cycle.
- SCAN, en=0: hold select, digit_idx, counter; frame_start = 0.
- digit_mask becomes 0 while in SCAN (en=1): next edge -> IDLE, select inactive, frame_start = 0.
- Current digit's mask bit cleared while in SCAN (en=1), other bits set: next edge advances immediately, without waiting for dwell; counter reloads. The frame_start rule applies to this advance.
- Exactly one mask bit set: select stays on that digit; frame_start pulses every dwell+1 cycles.
- dir or dwell change: sampled at the next advance or reload. The current dwell period completes unchanged.
- Invariant: select is exactly one-hot (after polarity) in SCAN and all-inactive in IDLE, every cycle.
- digit_idx always matches the asserted select bit.
- Reset mid-scan: outputs go to reset values immediately (asynchronous, no clock needed). Scan restarts from the first digit after rst falls and en=1.

Test Plan:
- Reset/start, DIGITS=8, dwell=0, mask=FF, dir=0, en=1 -> first select 80 with frame_start=1. Then 40, 20, 10, 08, 04, 02, 01, 80 on consecutive cycles; frame_start=1 only on each 80.
- Dwell and direction: dwell=2, dir=1, mask=FF -> 01 held 3 cycles, then 02 held 3 cycles, and so on; wraps 80 -> 01 with frame_start.
- Mask skip: mask=A5, dir=0, dwell=0 -> 80, 20, 04, 01, 80. Clearing bit 5 while 20 is selected -> next cycle 04; clearing all bits -> next edge select=00, IDLE.
- Single digit and freeze: mask=08, dwell=1 -> select stays 08, frame_start every 2nd cycle. en=0 for 5 cycles -> select, digit_idx and counter frozen, no frame_start.
- Reset mid-operation: assert rst between clock edges while select=10 -> select=00, digit_idx=0 immediately. After release, first select=80.
- ACTIVE_LOW=1, DIGITS=4, mask=F, dwell=0 -> select 7, B, D, E, 7; IDLE value F.
